// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared state type and constants for the 111 sequence detector
package seq_detect_pkg;

    localparam logic [1:0] ENC_S0 = 2'b00;
    localparam logic [1:0] ENC_S1 = 2'b01;
    localparam logic [1:0] ENC_S2 = 2'b10;
    localparam logic [1:0] ENC_S3 = 2'b11;

    // Number of consecutive ones that constitutes a detect
    localparam int DETECT_LEN = 3;

    // State name reflects how many trailing ones have been seen; S3 = detected
    typedef enum logic [1:0] {
        S0 = ENC_S0,
        S1 = ENC_S1,
        S2 = ENC_S2,
        S3 = ENC_S3
    } state_t;

endpackage

// File: rtl/seq_detect_111.sv
// rtl/seq_detect_111.sv - Moore detector flagging every run of three consecutive ones
module seq_detect_111
    import seq_detect_pkg::*;
#(
    parameter bit OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic X,
    output logic out
);

    state_t state;
    state_t state_next;

    // State register; reset discards any partial run
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: count trailing ones; after a detect either stay (overlap) or restart at one
    always_comb begin
        state_next = S0;
        case (state)
            S0:      state_next = X ? S1 : S0;
            S1:      state_next = X ? S2 : S0;
            S2:      state_next = X ? S3 : S0;
            S3:      state_next = X ? (OVERLAP ? S3 : S1) : S0;
            default: state_next = S0;
        endcase
    end

    // Flag is a pure decode of the state register, so X never reaches out combinationally
    assign out = (state == S3);

endmodule

// File: tb/tb_seq_detect_111.sv
// tb/tb_seq_detect_111.sv - directed self-checking bench for seq_detect_111 in both overlap modes
module tb_seq_detect_111;
    import seq_detect_pkg::*;

    logic clk;
    logic rst;
    logic X;
    logic out_ovl;
    logic out_nov;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic rst;
        logic x;
        logic exp_ovl;
        logic exp_nov;
    } vec_t;

    vec_t vecs[$];

    seq_detect_111 #(.OVERLAP(1'b1)) u_ovl (
        .clk (clk),
        .rst (rst),
        .X   (X),
        .out (out_ovl)
    );

    seq_detect_111 #(.OVERLAP(1'b0)) u_nov (
        .clk (clk),
        .rst (rst),
        .X   (X),
        .out (out_nov)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(logic r, logic x, logic eo, logic en);
        vec_t v;
        v.rst     = r;
        v.x       = x;
        v.exp_ovl = eo;
        v.exp_nov = en;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [1:0] act, logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge
    task automatic apply(logic r, logic x);
        @(negedge clk);
        rst = r;
        X   = x;
        @(posedge clk);
        #1;
    endtask

    task automatic step(string name, logic r, logic x, logic eo, logic en);
        apply(r, x);
        check({name, " ovl"}, {1'b0, out_ovl}, {1'b0, eo});
        check({name, " nov"}, {1'b0, out_nov}, {1'b0, en});
    endtask

    // Stimulus table plus hand-written corner sequences
    initial begin
        rst = 1'b1;
        X   = 1'bx;

        // Mixed stream: single detect after the 7th sample
        add(1, 1'bx, 0, 0);
        add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 1, 0, 0); add(0, 0, 0, 0);
        add(0, 1, 0, 0); add(0, 1, 0, 0); add(0, 1, 1, 1); add(0, 0, 0, 0);
        add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0);
        // Near miss: never three in a row
        add(1, 1'bx, 0, 0);
        add(0, 1, 0, 0); add(0, 1, 0, 0); add(0, 0, 0, 0);
        add(0, 1, 0, 0); add(0, 1, 0, 0); add(0, 0, 0, 0);
        // Run of five ones: overlap flags three times, non-overlap once
        add(1, 1'bx, 0, 0);
        add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 1, 0, 0); add(0, 1, 1, 1);
        add(0, 1, 1, 0); add(0, 1, 1, 0); add(0, 0, 0, 0);
        // Run of six ones: non-overlap flags after samples 3 and 6
        add(1, 1'bx, 0, 0);
        add(0, 1, 0, 0); add(0, 1, 0, 0); add(0, 1, 1, 1);
        add(0, 1, 1, 0); add(0, 1, 1, 0); add(0, 1, 1, 1);

        // Reset held two edges with X unknown
        step("reset0", 1'b1, 1'bx, 1'b0, 1'b0);
        step("reset1", 1'b1, 1'bx, 1'b0, 1'b0);
        check("reset state ovl", u_ovl.state, S0);
        check("reset state nov", u_nov.state, S0);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].x,
                 vecs[i].exp_ovl, vecs[i].exp_nov);
        end

        // Reset mid-run: a run straddling reset does not count
        step("mid rst", 1'b1, 1'bx, 1'b0, 1'b0);
        step("mid a", 1'b0, 1'b1, 1'b0, 1'b0);
        step("mid b", 1'b0, 1'b1, 1'b0, 1'b0);
        step("mid rst pulse", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < DETECT_LEN; i++) begin
            step($sformatf("post rst %0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
        end
        step("post rst detect", 1'b0, 1'b1, 1'b1, 1'b1);

        // Registered output: X toggling mid-cycle must not disturb out
        @(negedge clk);
        X = 1'b0;
        #1;
        check("no comb path ovl", {1'b0, out_ovl}, 2'b01);
        check("no comb path nov", {1'b0, out_nov}, 2'b01);
        @(posedge clk);
        #1;
        check("drop after zero ovl", {1'b0, out_ovl}, 2'b00);
        check("drop after zero nov", {1'b0, out_nov}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_111.md
Name: seq_detect_111

Overview:
- Serial bit-stream pattern detector: samples a 1-bit input once per clock and flags every occurrence of three consecutive 1s.
- Moore FSM with a registered output; the flag depends only on state.
- Standalone leaf block. Typical use: front-end of a serial protocol/framing checker.

Parameters:
- OVERLAP, 1, 1 = overlapping detection (a run of N≥3 ones flags N-2 times); 0 = non-overlapping (after a detect, counting restarts from zero ones).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- X  input  1  serial data bit, sampled on every rising clk edge
- out  output  1  detect flag, high for a full cycle after the third consecutive 1 is sampled

Behaviour:
- One clock domain: clk. Reset rst is synchronous and active-high. It is sampled only at the rising edge of clk and takes priority over everything else.
- States (2-bit encoding):
  - S0 = no trailing 1s, encoding 00
  - S1 = one trailing 1, encoding 01
  - S2 = two trailing 1s, encoding 10
  - S3 = detected, encoding 11
- Reset: state <= S0, so out = 0 from the first edge at which rst=1. X is don't-care (may be X/Z) while rst=1.
- Transitions, evaluated at each rising edge with rst=0:
  - S0: X=1 -> S1; X=0 -> S0.
  - S1: X=1 -> S2; X=0 -> S0.
  - S2: X=1 -> S3; X=0 -> S0.
  - S3 with OVERLAP=1: X=1 -> S3; X=0 -> S0.
  - S3 with OVERLAP=0: X=1 -> S1; X=0 -> S0.
- Output: out = (state == S3). It is purely a decode of the state register; no combinational path from X to out.
- Latency: if X=1 is sampled at edges k-2, k-1 and k, out rises just after edge k and stays high until edge k+1 at least.
- Unknown X with rst=0 is not filtered. Verification keeps X defined whenever rst=0.
- Reset mid-stream: any partial run is discarded, and a run straddling the reset does not count.
- Unreachable encodings do not exist (all 4 used). A default branch returns to S0.

Decomposition:
- Shared package seq_detect_pkg holds:
  - the state typedef (S0..S3)
  - the encoding localparams
  - the detect-length constant (3)
- No sub-module: single always_ff for state, single always_comb for next-state, one output assign.

Test Plan:
- Reset: hold rst=1 for 2 edges with X unknown -> out=0, state=S0. Release rst -> out stays 0 until a run of three 1s.
- Mixed stream: after reset, apply X = 0,1,1,0,1,1,1,0,1,0,0,1 (one bit per edge) -> out=1 for exactly one cycle, immediately after the 7th sample; 0 elsewhere.
- Near miss: stream 1,1,0,1,1,0 -> out never asserts.
- Overlap (OVERLAP=1): stream 0,1,1,1,1,1,0 -> out high for 3 consecutive cycles, after samples 4, 5 and 6, then low.
- Non-overlap (OVERLAP=0): stream 1,1,1,1,1,1 -> out high after samples 3 and 6 only.
- Reset mid-run: stream 1,1, then rst=1 for one edge, then 1 -> no assert. Continue 1,1 -> out asserts after the third post-reset 1.
